// File: rtl/comp_pattern_gen_pkg.sv
// Shared definitions for the comparator pattern generator.
//   mode_e  : pattern mode codes, taken from the 2-bit mode input
//   state_e : run-control FSM state codes
//   PRBS_TAPS / prbs_step / prbs_init : 7-bit LFSR x^7 + x^6 + 1 helpers
package comp_pattern_gen_pkg;

  typedef enum logic [1:0] {
    MODE_COUNT = 2'd0,
    MODE_WALK  = 2'd1,
    MODE_PRBS  = 2'd2,
    MODE_HOLD  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Taps at bit 6 and bit 5 implement x^7 + x^6 + 1.
  localparam logic [6:0] PRBS_TAPS = 7'b110_0000;
  // An all-zero LFSR locks up, so a zero seed is replaced by this value.
  localparam logic [6:0] PRBS_ZERO_SUB = 7'h7F;

  function automatic logic [6:0] prbs_step(input logic [6:0] s);
    return {s[5:0], ^(s & PRBS_TAPS)};
  endfunction

  function automatic logic [6:0] prbs_init(input logic [6:0] seed, input logic [6:0] ch);
    logic [6:0] v;
    v = seed ^ ch;
    return (v == 7'd0) ? PRBS_ZERO_SUB : v;
  endfunction

endpackage

// File: rtl/comp_pattern_gen_lane.sv
// One channel of the pattern generator: a constant tag in the upper bits
// and a CW-bit pattern field (plus its private LFSR) in the low bits.
// Ports:
//   lctclk, lctrst : clock, asynchronous active-high reset
//   load           : load the initial value for 'mode' (accepted start)
//   advance        : step the pattern field once according to 'mode'
//   mode           : pattern mode used for load/advance
//   seed           : PRBS seed; the lane mixes in its own channel index
//   word           : {tag, field}
module comp_pattern_gen_lane
  import comp_pattern_gen_pkg::*;
#(
  parameter int W  = 8,
  parameter int CW = 4,
  parameter int CH = 0
) (
  input  logic         lctclk,
  input  logic         lctrst,
  input  logic         load,
  input  logic         advance,
  input  mode_e        mode,
  input  logic [6:0]   seed,
  output logic [W-1:0] word
);

  // Tag is channel index + 1, truncated to the bits above the field.
  localparam logic [W-CW-1:0] TAG = (W-CW)'(CH + 1);

  logic [CW-1:0] field;
  logic [6:0]    lfsr;
  logic [6:0]    lfsr_init;
  logic [6:0]    lfsr_next;

  assign lfsr_init = prbs_init(seed, 7'(CH));
  assign lfsr_next = prbs_step(lfsr);

  always_ff @(posedge lctclk or posedge lctrst) begin
    if (lctrst) begin
      field <= '0;
      lfsr  <= PRBS_ZERO_SUB;
    end else if (load) begin
      case (mode)
        MODE_WALK: field <= CW'(1);
        MODE_PRBS: begin
          lfsr  <= lfsr_init;
          field <= lfsr_init[CW-1:0];
        end
        default:   field <= '0;
      endcase
    end else if (advance) begin
      case (mode)
        MODE_COUNT: field <= field + CW'(1);
        // Rotate left by one; written with shifts so CW = 1 stays legal.
        MODE_WALK:  field <= (field << 1) | (field >> (CW - 1));
        MODE_PRBS: begin
          lfsr  <= lfsr_next;
          field <= lfsr_next[CW-1:0];
        end
        default:    field <= field;
      endcase
    end
  end

  assign word = {TAG, field};

endmodule

// File: rtl/comp_pattern_gen.sv
// Comparator-style test pattern generator for NCH channel groups.
// Channel c word {c+1, pattern field} appears on data_out[c*W +: W].
// Ports:
//   lctclk, lctrst : LCT clock, asynchronous active-high reset
//   mode           : pattern mode, latched on an accepted start
//   start, stop    : burst request / abort request
//   burst_len      : advances per burst (0 = continuous), latched on start
//   seed           : PRBS seed, applied on an accepted start
//   data_out       : all channel words
//   busy           : high while running
//   done           : one-cycle pulse when a finite burst completes
//   word_cnt       : advances performed in the current/last burst
// Handshake: start is a level sampled each edge; it is accepted only in IDLE
// with stop low. stop aborts a run on the next edge; that edge still advances.
module comp_pattern_gen
  import comp_pattern_gen_pkg::*;
#(
  parameter int NCH = 6,
  parameter int W   = 8,
  parameter int CW  = 4,
  parameter int BLW = 16
) (
  input  logic             lctclk,
  input  logic             lctrst,
  input  logic [1:0]       mode,
  input  logic             start,
  input  logic             stop,
  input  logic [BLW-1:0]   burst_len,
  input  logic [6:0]       seed,
  output logic [NCH*W-1:0] data_out,
  output logic             busy,
  output logic             done,
  output logic [BLW-1:0]   word_cnt
);

  state_e         state_q, state_d;
  mode_e          mode_q;
  mode_e          lane_mode;
  logic [BLW-1:0] burst_len_q;
  logic [BLW-1:0] word_cnt_q, word_cnt_d;
  logic           load;
  logic           advance;

  always_ff @(posedge lctclk or posedge lctrst) begin
    if (lctrst) begin
      state_q     <= ST_IDLE;
      word_cnt_q  <= '0;
      mode_q      <= MODE_COUNT;
      burst_len_q <= '0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      if (load) begin
        mode_q      <= mode_e'(mode);
        burst_len_q <= burst_len;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    load       = 1'b0;
    advance    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d    = ST_RUN;
          load       = 1'b1;
          word_cnt_d = '0;
        end
      end
      ST_RUN: begin
        advance    = 1'b1;
        word_cnt_d = word_cnt_q + BLW'(1);
        // stop takes priority even on the final advance: no done pulse.
        if (stop)
          state_d = ST_IDLE;
        else if ((burst_len_q != '0) && (word_cnt_q == burst_len_q - BLW'(1)))
          state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // The lanes need the incoming mode on the load edge, the latched one after.
  assign lane_mode = load ? mode_e'(mode) : mode_q;

  for (genvar c = 0; c < NCH; c++) begin : g_lane
    comp_pattern_gen_lane #(
      .W  (W),
      .CW (CW),
      .CH (c)
    ) u_lane (
      .lctclk  (lctclk),
      .lctrst  (lctrst),
      .load    (load),
      .advance (advance),
      .mode    (lane_mode),
      .seed    (seed),
      .word    (data_out[c*W +: W])
    );
  end

  assign busy     = (state_q == ST_RUN);
  assign done     = (state_q == ST_DONE);
  assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_comp_pattern_gen.sv
module tb_comp_pattern_gen;

  localparam int NCH = 6;
  localparam int W   = 8;
  localparam int CW  = 4;
  localparam int BLW = 16;

  // clock / reset
  logic lctclk = 1'b0;
  logic lctrst = 1'b1;
  always #5 lctclk = ~lctclk;

  logic [1:0]       mode = '0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic [BLW-1:0]   burst_len = '0;
  logic [6:0]       seed = '0;
  logic [NCH*W-1:0] data_out;
  logic             busy;
  logic             done;
  logic [BLW-1:0]   word_cnt;

  comp_pattern_gen #(.NCH(NCH), .W(W), .CW(CW), .BLW(BLW)) dut (
    .lctclk    (lctclk),
    .lctrst    (lctrst),
    .mode      (mode),
    .start     (start),
    .stop      (stop),
    .burst_len (burst_len),
    .seed      (seed),
    .data_out  (data_out),
    .busy      (busy),
    .done      (done),
    .word_cnt  (word_cnt)
  );

  int n_cmp = 0;
  int n_err = 0;

  // behavioural reference model
  bit m_run;
  bit m_done;
  int m_cnt;
  int m_blen;
  int m_mode;
  int m_field [NCH];
  int m_pos   [NCH];
  int m_lfsr  [NCH];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_done = 0; m_cnt = 0; m_blen = 0; m_mode = 0;
    for (int c = 0; c < NCH; c++) begin
      m_field[c] = 0; m_pos[c] = 0; m_lfsr[c] = 127;
    end
  endtask

  function automatic int lfsr_next(input int l);
    int fb;
    fb = ((l >> 6) ^ (l >> 5)) & 1;
    return ((l << 1) | fb) & 127;
  endfunction

  task automatic model_step();
    if (m_run) begin
      for (int c = 0; c < NCH; c++) begin
        case (m_mode)
          0: m_field[c] = (m_field[c] + 1) % (1 << CW);
          1: begin
            m_pos[c] = (m_pos[c] + 1) % CW;
            m_field[c] = 1 << m_pos[c];
          end
          2: begin
            m_lfsr[c] = lfsr_next(m_lfsr[c]);
            m_field[c] = m_lfsr[c] % (1 << CW);
          end
          default: ;
        endcase
      end
      m_cnt = (m_cnt + 1) % (1 << BLW);
      if (stop) m_run = 0;
      else if (m_blen != 0 && m_cnt == m_blen) begin
        m_run = 0; m_done = 1;
      end
    end else if (m_done) begin
      m_done = 0;
    end else if (start && !stop) begin
      m_run = 1; m_cnt = 0; m_mode = int'(mode); m_blen = int'(burst_len);
      for (int c = 0; c < NCH; c++) begin
        case (m_mode)
          1: begin m_pos[c] = 0; m_field[c] = 1; end
          2: begin
            m_lfsr[c] = (int'(seed) ^ c) & 127;
            if (m_lfsr[c] == 0) m_lfsr[c] = 127;
            m_field[c] = m_lfsr[c] % (1 << CW);
          end
          default: m_field[c] = 0;
        endcase
      end
    end
  endtask

  function automatic logic [NCH*W-1:0] exp_data();
    logic [NCH*W-1:0] d;
    logic [W-1:0] wd;
    d = '0;
    for (int c = 0; c < NCH; c++) begin
      wd = W'((((c + 1) % (1 << (W - CW))) << CW) + m_field[c]);
      d[c*W +: W] = wd;
    end
    return d;
  endfunction

  task automatic compare_all(input string tag);
    check({tag, ".data"}, 64'(data_out), 64'(exp_data()));
    check({tag, ".busy"}, 64'(busy), 64'(m_run));
    check({tag, ".done"}, 64'(done), 64'(m_done));
    check({tag, ".cnt"},  64'(word_cnt), 64'(m_cnt));
  endtask

  // driver tasks
  task automatic tick(input string tag);
    @(posedge lctclk);
    model_step();
    #1;
    compare_all(tag);
  endtask

  task automatic ticks(input string tag, input int n);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  task automatic begin_burst(input string tag, input int md, input int blen, input int sd);
    mode = 2'(md); burst_len = BLW'(blen); seed = 7'(sd);
    start = 1'b1;
    tick(tag);
    start = 1'b0;
  endtask

  initial begin
    model_reset();
    #3;
    compare_all("reset");
    @(negedge lctclk);
    lctrst = 1'b0;
    ticks("idle", 8);

    // COUNT burst of 20
    begin_burst("count20", 0, 20, 0);
    ticks("count20", 24);

    // WALK continuous, stopped on the 9th advance
    begin_burst("walk", 1, 0, 0);
    ticks("walk", 8);
    stop = 1'b1;
    tick("walk_stop");
    stop = 1'b0;
    ticks("walk_after", 3);

    // PRBS, seed 0, 200 advances
    begin_burst("prbs", 2, 200, 0);
    ticks("prbs", 203);

    // HOLD
    begin_burst("hold", 3, 6, 9);
    ticks("hold", 8);

    // start&stop together, then start during RUN
    start = 1'b1; stop = 1'b1;
    tick("startstop");
    start = 1'b0; stop = 1'b0;
    tick("startstop");
    begin_burst("restart", 0, 0, 0);
    ticks("restart", 3);
    start = 1'b1;
    tick("restart_ign");
    start = 1'b0;
    ticks("restart", 2);
    stop = 1'b1;
    tick("restart_stop");
    stop = 1'b0;

    // stop on the final advance edge
    begin_burst("laststop", 0, 5, 0);
    ticks("laststop", 4);
    stop = 1'b1;
    tick("laststop_edge");
    stop = 1'b0;
    ticks("laststop_after", 3);

    // start held through the completion and DONE cycles
    begin_burst("donestart", 1, 3, 0);
    ticks("donestart", 2);
    start = 1'b1;
    ticks("donestart_ign", 2);
    start = 1'b0;
    ticks("donestart", 2);

    // asynchronous reset mid-burst at word_cnt = 7
    begin_burst("rstmid", 0, 50, 0);
    ticks("rstmid", 7);
    #2;
    lctrst = 1'b1;
    #1;
    model_reset();
    compare_all("rstmid_async");
    @(negedge lctclk);
    lctrst = 1'b0;
    ticks("rstmid_after", 4);

    // randomized control traffic
    for (int i = 0; i < 1500; i++) begin
      start = ($urandom_range(0, 5) == 0);
      stop  = ($urandom_range(0, 19) == 0);
      mode  = 2'($urandom_range(0, 3));
      burst_len = BLW'($urandom_range(0, 14));
      seed  = 7'($urandom_range(0, 127));
      tick("rand");
    end
    start = 1'b0; stop = 1'b0;
    ticks("tail", 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
